// File: rtl/float_to_int_pkg.sv
// Shared definitions for the float-to-integer converter and its float unpack helper.
// Holds the FSM encoding and the IEEE-754 single-precision constants.
package float_to_int_pkg;

  typedef enum logic [2:0] {
    ST_GET_A         = 3'd0,
    ST_UNPACK        = 3'd1,
    ST_SPECIAL_CASES = 3'd2,
    ST_CONVERT       = 3'd3,
    ST_PUT_Z         = 3'd4
  } state_t;

  localparam logic [9:0]  FLT_BIAS        = 10'd127;
  localparam logic [7:0]  FLT_EXP_SPECIAL = 8'd255;
  localparam logic [31:0] INT32_MIN       = 32'h8000_0000;

endpackage

// File: rtl/float_to_int_unpack.sv
// Combinational IEEE-754 single field split: sign, unbiased exponent and
// left-justified mantissa with the hidden bit restored.
module float_unpack
  import float_to_int_pkg::*;
(
  input  logic [31:0] a,
  output logic        sign,
  output logic [9:0]  exp_unbiased,
  output logic [31:0] mantissa,
  output logic        exp_special
);

  // Field extraction; exponent is signed in 10 bits so -127..128 fits.
  always_comb begin
    sign         = a[31];
    exp_unbiased = {2'b00, a[30:23]} - FLT_BIAS;
    mantissa     = {1'b1, a[22:0], 8'b0000_0000};
    exp_special  = (a[30:23] == FLT_EXP_SPECIAL);
  end

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero, saturating
// NaN/inf/out-of-range to INT32_MIN. Strobe/acknowledge handshake on both sides.
module float_to_int
  import float_to_int_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t      state_r;
  logic [31:0] a_r;
  logic [31:0] m_r;
  logic [9:0]  e_r;
  logic        s_r;
  logic [31:0] z_r;

  logic        sign_s;
  logic [9:0]  exp_s;
  logic [31:0] mant_s;
  logic        special_s;

  float_unpack u_unpack (
    .a            (a_r),
    .sign         (sign_s),
    .exp_unbiased (exp_s),
    .mantissa     (mant_s),
    .exp_special  (special_s)
  );

  // Conversion FSM: one bit of right shift per cycle until the binary point
  // reaches bit 0 (e == 31); bits shifted out give truncation toward zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'd0;
      a_r          <= 32'd0;
      m_r          <= 32'd0;
      e_r          <= 10'd0;
      s_r          <= 1'b0;
      z_r          <= 32'd0;
    end else begin
      case (state_r)
        ST_GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a_r         <= input_a;
            input_a_ack <= 1'b0;
            state_r     <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          m_r     <= mant_s;
          e_r     <= exp_s;
          s_r     <= sign_s;
          state_r <= ST_SPECIAL_CASES;
        end
        ST_SPECIAL_CASES: begin
          // e > 30 saturates; the only in-range value there is -2^31 itself.
          if (special_s) begin
            z_r     <= INT32_MIN;
            state_r <= ST_PUT_Z;
          end else if (e_r[9]) begin
            z_r     <= 32'd0;
            state_r <= ST_PUT_Z;
          end else if ($signed(e_r) > $signed(10'sd30)) begin
            z_r     <= INT32_MIN;
            state_r <= ST_PUT_Z;
          end else begin
            state_r <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (e_r == 10'd31) begin
            z_r     <= s_r ? (~m_r + 32'd1) : m_r;
            state_r <= ST_PUT_Z;
          end else begin
            m_r <= m_r >> 1;
            e_r <= e_r + 10'd1;
          end
        end
        ST_PUT_Z: begin
          output_z_stb <= 1'b1;
          output_z     <= z_r;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state_r      <= ST_GET_A;
          end
        end
        default: begin
          state_r      <= ST_GET_A;
          input_a_ack  <= 1'b0;
          output_z_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed corner values, back-pressure,
// mid-conversion reset and a random back-to-back stream against a real-valued model.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = 32'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: real value of the float, truncated toward zero, saturated to INT32_MIN.
  function automatic logic [31:0] ref_int(input logic [31:0] f);
    int  ex;
    real mag;
    real x;
    ex = int'(f[30:23]);
    if (ex == 255) return 32'h8000_0000;
    if (ex == 0) mag = real'(f[22:0]) * (2.0 ** (-149.0));
    else         mag = real'(32'd8388608 + {9'd0, f[22:0]}) * (2.0 ** real'(ex - 150));
    x = f[31] ? -mag : mag;
    if (x >= 2147483648.0 || x < -2147483648.0) return 32'h8000_0000;
    return $rtoi(x);
  endfunction

  // Reference latency (edges after the input transfer until output_z_stb is seen high).
  function automatic int ref_lat(input logic [31:0] f);
    int ex;
    ex = int'(f[30:23]);
    if (ex == 255 || ex < 127 || ex > 157) return 3;
    return 4 + (31 - (ex - 127));
  endfunction

  task automatic convert(input logic [31:0] f, input string tag, input bit keep_stb);
    int waited;
    int lat;
    waited = 0;
    input_a     = f;
    input_a_stb = 1'b1;
    while (input_a_ack !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (input_a_ack !== 1'b1) begin
      chk({tag, "_ack_wait"}, {31'd0, input_a_ack}, 32'd1);
      input_a_stb = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!keep_stb) input_a_stb = 1'b0;
    lat = 0;
    while (output_z_stb !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, ref_lat(f));
    chk({tag, "_val"}, output_z, ref_int(f));
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    chk({tag, "_stb_drop"}, {31'd0, output_z_stb}, 32'd0);
    chk({tag, "_ack_low"}, {31'd0, input_a_ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] dir_vals [15];
    logic [31:0] held;
    logic [31:0] rv;
    int          seen;

    dir_vals = '{32'h3F80_0000, 32'hC020_0000, 32'h4B7F_FFFF, 32'h3F40_0000,
                 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h4F00_0000,
                 32'hCF00_0000, 32'h4EFF_FFFF, 32'h7F80_0000, 32'h7FC0_0000,
                 32'h4EFF_FFFE, 32'hBF7F_FFFF, 32'h4040_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, input_a_ack}, 32'd0);
    chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("rst_z", output_z, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ack_rise", {31'd0, input_a_ack}, 32'd1);

    // Spot-check the model on a few hand-derived constants before relying on it
    chk("model_1p0", ref_int(32'h3F80_0000), 32'h0000_0001);
    chk("model_m2p5", ref_int(32'hC020_0000), 32'hFFFF_FFFE);
    chk("model_big", ref_int(32'h4EFF_FFFF), 32'h7FFF_FF80);

    foreach (dir_vals[i]) convert(dir_vals[i], $sformatf("dir%0d", i), 1'b0);

    // Back-pressure: hold output_z_ack low for 10 cycles
    input_a     = 32'hC020_0000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    seen = 0;
    while (output_z_stb !== 1'b1 && seen < 60) begin
      @(posedge clk); #1;
      seen++;
    end
    held = output_z;
    chk("bp_val", held, 32'hFFFF_FFFE);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_stb", {31'd0, output_z_stb}, 32'd1);
      chk("bp_z", output_z, 32'hFFFF_FFFE);
      chk("bp_in_ack", {31'd0, input_a_ack}, 32'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    chk("bp_rel_stb", {31'd0, output_z_stb}, 32'd0);
    chk("bp_rel_ack", {31'd0, input_a_ack}, 32'd0);
    @(posedge clk); #1;
    chk("bp_ack_rise", {31'd0, input_a_ack}, 32'd1);

    // Reset during convert of 1.0
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ack", {31'd0, input_a_ack}, 32'd0);
    chk("mid_rst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("mid_rst_z", output_z, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (output_z_stb === 1'b1) seen++;
    end
    chk("mid_rst_no_out", seen, 32'd0);
    convert(32'h4040_0000, "after_rst", 1'b0);
    chk("after_rst_3", output_z, 32'h0000_0003);

    // Back-to-back random finite stream with input_a_stb kept high
    for (int k = 0; k < 8; k++) begin
      rv        = $urandom;
      rv[30:23] = 8'($urandom_range(110, 165));
      convert(rv, $sformatf("rnd%0d", k), 1'b1);
    end
    input_a_stb = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
